div_32bit_seq: RTL and testbench
================================

// Module: div_32bit_seq
// PURPOSE
//  Sequential radix-2 restoring divider; the inverse datapath to the ALU's combinational multiplier.
//  Computes quotient and remainder for signed (DIV) or unsigned (DIVU) operands, one bit per clock.
//  Results feed the LO (quotient) and HI (remainder) registers of the datapath.
//  Uses a start/busy/done handshake so the control unit stalls until the result is valid.
// PARAMETERS
//  WIDTH  32  Operand, quotient and remainder width in bits.
// PORTS
//  clk          in   1      System clock; all state changes on the rising edge.
//  clear_n      in   1      Synchronous active-low reset.
//  start        in   1      Request a divide; sampled only in IDLE.
//  signed_op    in   1      1 = two's-complement divide, 0 = unsigned divide; sampled with start.
//  dividend     in   WIDTH  Dividend; sampled with start.
//  divisor      in   WIDTH  Divisor; sampled with start.
//  quotient     out  WIDTH  Registered quotient (to LO).
//  remainder    out  WIDTH  Registered remainder (to HI).
//  busy         out  1      High from the edge after start is accepted until done asserts.
//  done         out  1      One-cycle pulse: quotient/remainder/div_by_zero are valid.
//  div_by_zero  out  1      Set with done when divisor == 0; held until the next accepted start.
// BEHAVIOUR
//  - Reset (clear_n = 0 at a rising edge): state IDLE; quotient, remainder, busy, done, div_by_zero = 0.
//    Reset mid-operation aborts it; no done is produced.
//  - FSM states: IDLE, ITER, FINISH.
//    - IDLE: start = 1 at edge E0 latches operands. In signed mode the magnitudes |dividend| and
//      |divisor| are loaded; sign_q = dividend[W-1]^divisor[W-1] and sign_r = dividend[W-1] are latched.
//      The partial remainder is cleared, count = WIDTH-1 and busy is set.
//      If divisor == 0, go to FINISH; otherwise go to ITER.
//    - ITER: each edge shifts {rem,quo} left by 1, then trial-subtracts the divisor from the WIDTH+1-bit
//      partial remainder. If the result is non-negative, keep it and set quo[0] = 1; else restore and set
//      quo[0] = 0. Decrement count. The edge that processes count == 0 moves to FINISH,
//      so ITER occupies edges E1..E32 for WIDTH = 32.
//    - FINISH: one edge (E33) writes the outputs, asserts done, clears busy and returns to IDLE.
//      done is high for exactly the cycle between E33 and E34.
//  - Sign fix-up (signed_op = 1): quotient negated if sign_q; remainder negated if sign_r.
//    The remainder therefore carries the sign of the dividend (truncating division).
//  - Latency: done visible 33 edges after start is accepted (normal); 1 edge after (divide by zero).
//  - Divide by zero: quotient = all ones, remainder = dividend as presented, div_by_zero = 1.
//  - Overflow (signed -2^(W-1) / -1): quotient = 0x8000_0000 (wraps), remainder = 0. No flag is raised.
//  - Magnitude of -2^(W-1) is handled as unsigned 2^(W-1); a WIDTH-bit unsigned datapath suffices.
//  - start while busy (ITER or FINISH) is ignored; operands are not re-sampled.
//    start in the IDLE cycle right after done is accepted normally (back-to-back operations).
//  - quotient, remainder and div_by_zero hold their values between operations.
//  - divisor > dividend (unsigned magnitude): quotient 0, remainder = dividend, full 33-edge latency.
// STRUCTURE
//  - Shared package div_pkg: state typedef {IDLE, ITER, FINISH} and DIV_WIDTH = 32 default.
//  - One sub-module, cond_negate: WIDTH-bit conditional two's-complement (in, neg) -> out.
//    Instantiated for operand magnitude and result fix-up.
//  - Remaining logic (FSM, count, shift/subtract register) is in this module.
//    No multicycle paths; the WIDTH+1-bit subtractor is the critical path.
// TESTING
//  1. signed, 100 / 7, start at E0 -> busy after E0; done pulse after E33 only; q = 14, r = 2, dbz = 0.
//  2. signed, -100 / 7 -> q = -14 (0xFFFF_FFF2), r = -2 (0xFFFF_FFFE).
//     Also 100 / -7 -> q = -14, r = 2.
//  3. unsigned, 0xFFFF_FFFF / 2 -> q = 0x7FFF_FFFF, r = 1.
//     Same operands with signed_op = 1 -> q = 0, r = -1.
//  4. Divide by zero: 0x1234 / 0 -> done after E1; q = 0xFFFF_FFFF, r = 0x1234, dbz = 1.
//     Next normal divide -> dbz returns to 0.
//  5. signed 0x8000_0000 / 0xFFFF_FFFF -> q = 0x8000_0000, r = 0, dbz = 0.
//  6. Control hazards:
//     - clear_n low at E10 -> busy = done = q = r = 0, no done ever.
//     - start pulsed at E5 while busy, operands changed -> result of the original operands,
//       done after E33 only.
//     - back-to-back start on the cycle after done -> second result after its own 33 edges.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential radix-2 restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ITER   = 2'd1,
        FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement: passes din through, or returns -din when neg is set.
module cond_negate
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/div_32bit_seq.sv
// Radix-2 restoring divider, one quotient bit per clock, signed (truncating) or unsigned.
// Operands are reduced to magnitudes on entry and the signs are re-applied in FINISH.
module div_32bit_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    count_q, count_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [WIDTH-1:0] dvd_mag, dvs_mag, quo_fix, rem_fix;
    logic [WIDTH:0]   shifted, trial;

    cond_negate #(.WIDTH(WIDTH)) u_mag_dvd (
        .din (dividend),
        .neg (signed_op & dividend[WIDTH-1]),
        .dout(dvd_mag)
    );

    cond_negate #(.WIDTH(WIDTH)) u_mag_dvs (
        .din (divisor),
        .neg (signed_op & divisor[WIDTH-1]),
        .dout(dvs_mag)
    );

    cond_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .din (quo_q),
        .neg (neg_quo_q),
        .dout(quo_fix)
    );

    cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .din (rem_q),
        .neg (neg_rem_q),
        .dout(rem_fix)
    );

    // Bit WIDTH of the trial difference is its sign: a non-negative result is
    // always below the divisor, a negative one always has that bit set.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch.
        state_d       = state_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvs_d         = dvs_q;
        count_d       = count_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        dbz_pend_d    = dbz_pend_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    quo_d         = dvd_mag;
                    dvs_d         = dvs_mag;
                    rem_d         = '0;
                    count_d       = CW'(WIDTH - 1);
                    neg_quo_d     = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d     = signed_op & dividend[WIDTH-1];
                    busy_d        = 1'b1;
                    div_by_zero_d = 1'b0;
                    if (divisor == '0) begin
                        // Raw dividend is parked in rem so FINISH can return it unchanged.
                        dbz_pend_d = 1'b1;
                        rem_d      = dividend;
                        state_d    = FINISH;
                    end else begin
                        dbz_pend_d = 1'b0;
                        state_d    = ITER;
                    end
                end
            end

            ITER: begin
                if (trial[WIDTH]) begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
                count_d = count_q - CW'(1);
                if (count_q == '0) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                if (dbz_pend_q) begin
                    quotient_d    = '1;
                    remainder_d   = rem_q;
                    div_by_zero_d = 1'b1;
                end else begin
                    quotient_d    = quo_fix;
                    remainder_d   = rem_fix;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!clear_n) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            count_q       <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_pend_q    <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvs_q         <= dvs_d;
            count_q       <= count_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            dbz_pend_q    <= dbz_pend_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_div_32bit_seq.sv
// Self-checking bench for div_32bit_seq: arithmetic reference model with cycle-level timing,
// a per-cycle compare process, directed cases pinned to literals and randomized divides.
module tb_div_32bit_seq;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } res_t;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient, remainder;
    logic        busy, done, div_by_zero;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    div_32bit_seq dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        res_t   res;
        longint sa, sb;
        if (b == 32'd0) begin
            res.q   = 32'hFFFF_FFFF;
            res.r   = a;
            res.dbz = 1'b1;
        end else if (s) begin
            sa      = longint'($signed(a));
            sb      = longint'($signed(b));
            res.q   = 32'(sa / sb);
            res.r   = 32'(sa % sb);
            res.dbz = 1'b0;
        end else begin
            res.q   = a / b;
            res.r   = a % b;
            res.dbz = 1'b0;
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one pending result with a countdown of remaining edges.
    res_t        m_res;
    logic [31:0] m_q = '0, m_r = '0;
    logic        m_dbz = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_pend = 1'b0;
    int          m_left = 0;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (!clear_n) begin
            m_pend <= 1'b0;
            m_busy <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_dbz  <= 1'b0;
        end else if (m_pend) begin
            if (m_left == 1) begin
                m_q    <= m_res.q;
                m_r    <= m_res.r;
                m_dbz  <= m_res.dbz;
                m_done <= 1'b1;
                m_busy <= 1'b0;
                m_pend <= 1'b0;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (start) begin
            m_res  <= ref_div(dividend, divisor, signed_op);
            m_left <= (divisor == 32'd0) ? 1 : 33;
            m_pend <= 1'b1;
            m_busy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("quotient", quotient, m_q);
            check("remainder", remainder, m_r);
            if (!m_pend) check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        #1;
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        signed_op = s;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] eq, input logic [31:0] er,
                           input logic edbz);
        res_t m;
        m = ref_div(a, b, s);
        check({name, "_model_q"}, m.q, eq);
        check({name, "_model_r"}, m.r, er);
        start_op(a, b, s);
        wait_done();
        check({name, "_q"}, quotient, eq);
        check({name, "_r"}, remainder, er);
        check({name, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    endtask

    initial begin
        logic [31:0] a, b;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_q", quotient, 32'd0);
        check("reset_r", remainder, 32'd0);
        check("reset_dbz", 32'(div_by_zero), 32'd0);
        #1 clear_n = 1'b1;
        @(negedge clk);

        run_lit("s_100_7", 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
        run_lit("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run_lit("s_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0);
        run_lit("u_ff_2", 32'hFFFF_FFFF, 32'd2, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0);
        run_lit("s_ff_2", 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_lit("dbz", 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
        repeat (3) @(negedge clk);
        run_lit("after_dbz", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        run_lit("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        run_lit("small_big", 32'd5, 32'd100, 1'b0, 32'd0, 32'd5, 1'b0);

        // Abort by reset at the tenth edge after acceptance.
        start_op(32'd100, 32'd7, 1'b1);
        repeat (9) @(negedge clk);
        #1 clear_n = 1'b0;
        @(negedge clk);
        #1 clear_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_q", quotient, 32'd0);
        check("abort_r", remainder, 32'd0);

        // A start while busy with different operands must be ignored.
        start_op(32'd100, 32'd7, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        start    = 1'b1;
        dividend = 32'd999;
        divisor  = 32'd3;
        @(negedge clk);
        #1 start = 1'b0;
        wait_done();
        check("ignored_start_q", quotient, 32'd14);
        check("ignored_start_r", remainder, 32'd2);

        // Back-to-back: the second start is issued in the cycle done is high.
        run_lit("b2b_first", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0);
        run_lit("b2b_second", 32'd1001, 32'd10, 1'b0, 32'd100, 32'd1, 1'b0);

        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: b = a;
                4: b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            start_op(a, b, 1'($urandom_range(0, 1)));
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
